// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared types and constants for the frame-buffer access arbiter
//
// Purpose: owner-state enum, frame geometry, starvation limit and the
// write-entry layout used by fb_access_arbiter and its testbench.
// Ports: none (package).
package fb_pkg;

  localparam int FB_DEPTH   = 90000;  // 300x300 pixels
  localparam int FB_ADDR_W  = 18;
  localparam int FB_DATA_W  = 8;
  localparam int STARVE_LIM = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } owner_e;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// rtl/fb_wr_fifo.sv - small synchronous write FIFO with registered flags
//
// Purpose: buffers pixel writes until the SRAM port is free of display reads.
// DEPTH must be a power of two (pointers wrap naturally).
// Ports:
//   clk, reset      pixel clock, asynchronous active-low reset (empties FIFO)
//   push, push_data enqueue one entry (caller guarantees !full)
//   pop             dequeue the head (caller guarantees !empty)
//   head            current oldest entry, read straight from storage flops
//   full, empty     registered occupancy flags
module fb_wr_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Flags come from the next count so they are plain flops; a pop frees
    // space one edge later, never combinationally.
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/fb_access_arbiter.sv
// rtl/fb_access_arbiter.sv - single-port frame SRAM arbiter, display reads first
//
// Purpose: shares one SRAM port between display scan-out (strict priority,
// fixed 2-cycle latency) and a buffered pixel write client.
// Optional feature macro: FB_ARB_STATS_EN (drop counter and starvation flag).
// Ports:
//   clk, reset                      pixel clock, asynchronous active-low reset
//   disp_req, disp_addr             display read request / address
//   disp_valid, disp_data           read return, two edges after the request
//   wr_valid, wr_ready, wr_addr,    write offer handshake; out-of-range
//   wr_data                         addresses are accepted and dropped
//   mem_addr, mem_we, mem_wdata     registered SRAM controls
//   mem_rdata                       SRAM read data (one cycle after address)
//   drop_cnt                        saturating count of dropped writes
//   starve                          sticky write-starvation flag
module fb_access_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int DATA_W     = FB_DATA_W,
  parameter int DEPTH      = FB_DEPTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       drop_cnt,
  output logic              starve
);

  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(DEPTH);

  owner_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              rd_pend_q, rd_pend_d;
  logic              disp_valid_q, disp_valid_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;

  logic              wr_hs;
  logic              wr_in_range;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ENT_W-1:0]  fifo_head;

  assign wr_hs       = wr_valid && wr_ready;
  assign wr_in_range = (wr_addr < DEPTH_LIM);
  assign fifo_push   = wr_hs && wr_in_range;
  assign wr_ready    = !fifo_full;

  fb_wr_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({wr_addr, wr_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // The SRAM controls are registered from the next owner, so the access
  // decided at an edge is presented on the port right after that edge.
  always_comb begin
    state_d = ST_IDLE;
    if (disp_req) begin
      state_d = ST_READ;
    end else if (!fifo_empty) begin
      state_d = ST_WRITE;
    end

    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    fifo_pop    = 1'b0;
    case (state_d)
      ST_READ: begin
        mem_addr_d = disp_addr;
      end
      ST_WRITE: begin
        mem_addr_d  = fifo_head[ENT_W-1:DATA_W];
        mem_wdata_d = fifo_head[DATA_W-1:0];
        mem_we_d    = 1'b1;
        fifo_pop    = 1'b1;
      end
      default: begin
        mem_addr_d = mem_addr_q;
      end
    endcase

    // state_q == ST_READ: address is on the port, RAM samples it this cycle;
    // its data is captured on the following edge.
    rd_pend_d    = (state_q == ST_READ);
    disp_valid_d = rd_pend_q;
    disp_data_d  = rd_pend_q ? mem_rdata : disp_data_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      rd_pend_q    <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      rd_pend_q    <= rd_pend_d;
      disp_valid_q <= disp_valid_d;
      disp_data_q  <= disp_data_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign disp_valid = disp_valid_q;
  assign disp_data  = disp_data_q;

`ifdef FB_ARB_STATS_EN
  localparam int SC_W = $clog2(STARVE_LIM) + 1;
  localparam logic [SC_W-1:0] SC_LIM = SC_W'(STARVE_LIM);

  logic [15:0]     drop_cnt_q, drop_cnt_d;
  logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;
  logic            starve_q, starve_d;
  logic            starve_cond;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (wr_hs && !wr_in_range && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end

    // Any cycle that is not "full and display owns the port" breaks the
    // run, which includes every ST_WRITE cycle.
    starve_cond  = fifo_full && (state_q == ST_READ);
    starve_cnt_d = '0;
    if (starve_cond) begin
      starve_cnt_d = (starve_cnt_q == SC_LIM) ? SC_LIM : starve_cnt_q + 1'b1;
    end
    starve_d = starve_q || (starve_cnt_d == SC_LIM);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_q   <= '0;
      starve_cnt_q <= '0;
      starve_q     <= 1'b0;
    end else begin
      drop_cnt_q   <= drop_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      starve_q     <= starve_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign starve   = starve_q;
`else
  assign drop_cnt = '0;
  assign starve   = 1'b0;
`endif

endmodule

// File: tb/tb_fb_access_arbiter.sv
// tb/tb_fb_access_arbiter.sv - directed self-checking bench for fb_access_arbiter
module tb_fb_access_arbiter;
  import fb_pkg::*;

`ifdef FB_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        disp_req;
  logic [17:0] disp_addr;
  logic        disp_valid;
  logic [7:0]  disp_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [17:0] wr_addr;
  logic [7:0]  wr_data;
  logic [17:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic [15:0] drop_cnt;
  logic        starve;

  int n_cmp = 0;
  int n_bad = 0;
  int we_seen;

  always #20 clk = ~clk;

  fb_access_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .drop_cnt   (drop_cnt),
    .starve     (starve)
  );

  // Synchronous single-port SRAM, read-first, preloaded with data = addr[7:0].
  logic [7:0] ram [0:(1<<FB_ADDR_W)-1];
  logic       preloaded = 1'b0;
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < (1 << FB_ADDR_W); i++) ram[i] <= 8'(i);
      preloaded <= 1'b1;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic offer(input logic [17:0] a, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
  endtask

  // Request n consecutive reads and expect data dbase+k two edges after each.
  task automatic do_reads(input logic [17:0] base, input int n, input logic [7:0] dbase);
    for (int j = 0; j < n + 3; j++) begin
      @(negedge clk);
      if (j >= 3) begin
        check_eq("rd_valid", 32'(disp_valid), 32'd1);
        check_eq("rd_data", 32'(disp_data), 32'(8'(dbase + 8'(j - 3))));
      end else begin
        check_eq("rd_lead_valid", 32'(disp_valid), 32'd0);
      end
      if (j < n) begin
        disp_req  = 1'b1;
        disp_addr = base + 18'(j);
      end else begin
        disp_req = 1'b0;
      end
    end
    @(negedge clk);
    check_eq("rd_tail_valid", 32'(disp_valid), 32'd0);
  endtask

  initial begin
    reset     = 1'b0;
    disp_req  = 1'b0;
    disp_addr = '0;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    repeat (3) @(negedge clk);

    // Reset values
    check_eq("rst_disp_valid", 32'(disp_valid), 32'd0);
    check_eq("rst_disp_data", 32'(disp_data), 32'd0);
    check_eq("rst_wr_ready", 32'(wr_ready), 32'd1);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check_eq("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check_eq("rst_starve", 32'(starve), 32'd0);
    reset = 1'b1;

    we_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (mem_we) we_seen++;
    end
    check_eq("idle_no_we", 32'(we_seen), 32'd0);
    check_eq("idle_disp_valid", 32'(disp_valid), 32'd0);

    // Back-to-back display reads 0..9
    do_reads(18'd0, 10, 8'h00);

    // Four writes with display idle: each written one edge after acceptance
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (j < 4) check_eq("wq_ready", 32'(wr_ready), 32'd1);
      if (j >= 2 && j <= 5) begin
        check_eq("wq_we", 32'(mem_we), 32'd1);
        check_eq("wq_addr", 32'(mem_addr), 32'(100 + j - 2));
        check_eq("wq_wdata", 32'(mem_wdata), 32'(8'hA0 + j - 2));
      end else begin
        check_eq("wq_we_idle", 32'(mem_we), 32'd0);
      end
      if (j < 4) offer(18'(100 + j), 8'(8'hA0 + j));
      else wr_valid = 1'b0;
    end
    do_reads(18'd100, 4, 8'hA0);

    // Writes blocked by continuous display reads, then drained
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check_eq("blk_no_we", 32'(mem_we), 32'd0);
      check_eq("blk_ready", 32'(wr_ready), (j < 4) ? 32'd1 : 32'd0);
      disp_req  = 1'b1;
      disp_addr = '0;
      if (j < 4) offer(18'(200 + j), 8'(8'hB0 + j));
      else offer(18'd204, 8'hBF);
    end
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      if (j >= 1 && j <= 4) begin
        check_eq("drn_we", 32'(mem_we), 32'd1);
        check_eq("drn_addr", 32'(mem_addr), 32'(200 + j - 1));
        check_eq("drn_wdata", 32'(mem_wdata), 32'(8'hB0 + j - 1));
      end else begin
        check_eq("drn_we_idle", 32'(mem_we), 32'd0);
      end
      if (j == 1) check_eq("drn_ready", 32'(wr_ready), 32'd1);
      disp_req = 1'b0;
      wr_valid = 1'b0;
    end

    // Out-of-range write is accepted and dropped; last valid address is kept
    @(negedge clk);
    check_eq("oor_ready", 32'(wr_ready), 32'd1);
    offer(18'd90000, 8'h77);
    @(negedge clk);
    wr_valid = 1'b0;
    we_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_we) we_seen++;
    end
    check_eq("oor_no_we", 32'(we_seen), 32'd0);
    check_eq("oor_drop_cnt", 32'(drop_cnt), STATS ? 32'd1 : 32'd0);
    offer(18'd89999, 8'h5A);
    @(negedge clk);
    wr_valid = 1'b0;
    check_eq("edge_we_wait", 32'(mem_we), 32'd0);
    @(negedge clk);
    check_eq("edge_we", 32'(mem_we), 32'd1);
    check_eq("edge_addr", 32'(mem_addr), 32'd89999);
    check_eq("edge_wdata", 32'(mem_wdata), 32'h5A);
    check_eq("edge_drop_cnt", 32'(drop_cnt), STATS ? 32'd1 : 32'd0);

    // Starvation: FIFO full from the 4th push edge, then 1024 read cycles
    for (int j = 0; j < 1029; j++) begin
      @(negedge clk);
      if (j == 1027) check_eq("starve_before", 32'(starve), 32'd0);
      if (j == 1028) begin
        check_eq("starve_set", 32'(starve), STATS ? 32'd1 : 32'd0);
        check_eq("starve_full", 32'(wr_ready), 32'd0);
      end
      disp_req  = 1'b1;
      disp_addr = '0;
      if (j < 4) offer(18'(300 + j), 8'(8'hC0 + j));
      else wr_valid = 1'b0;
    end
    @(negedge clk);
    disp_req = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("starve_drained", 32'(wr_ready), 32'd1);
    check_eq("starve_sticky", 32'(starve), STATS ? 32'd1 : 32'd0);

    // Reset in the middle of a drain with a read in flight
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      disp_req  = 1'b1;
      disp_addr = 18'(j);
      offer(18'(400 + j), 8'(8'hD0 + j));
    end
    @(negedge clk);
    wr_valid = 1'b0;
    disp_req = 1'b0;
    @(negedge clk);
    check_eq("mid_we", 32'(mem_we), 32'd1);
    check_eq("pre_rst_valid", 32'(disp_valid), 32'd1);
    reset = 1'b0;
    #1;
    check_eq("mrst_disp_valid", 32'(disp_valid), 32'd0);
    check_eq("mrst_wr_ready", 32'(wr_ready), 32'd1);
    check_eq("mrst_starve", 32'(starve), 32'd0);
    check_eq("mrst_mem_we", 32'(mem_we), 32'd0);
    check_eq("mrst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("mrst_drop_cnt", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    we_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_we) we_seen++;
    end
    check_eq("post_rst_no_we", 32'(we_seen), 32'd0);
    check_eq("post_rst_valid", 32'(disp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
